// File: rtl/heap_ctrl.sv
// Binary heap engine driving one synchronous-read memory port; min-heap by default.
// Define HEAP_MAX_EN to build a max-heap (strict greater-than ordering) instead.
module heap_ctrl #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          err,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_PU_RD   = 4'd1;
  localparam logic [3:0] S_PU_CMP  = 4'd2;
  localparam logic [3:0] S_WR      = 4'd3;
  localparam logic [3:0] S_PO_ROOT = 4'd4;
  localparam logic [3:0] S_PO_LAST = 4'd5;
  localparam logic [3:0] S_PD_RDL  = 4'd6;
  localparam logic [3:0] S_PD_RDR  = 4'd7;
  localparam logic [3:0] S_PD_CMP  = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;

  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   IDX_TWO = {{(AW-1){1'b0}}, 2'b10};

  function automatic logic better(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef HEAP_MAX_EN
    return a > b;
`else
    return a < b;
`endif
  endfunction

  logic [3:0]    state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] hole_q, hole_d;
  logic [DW-1:0] key_q, key_d;
  logic [DW-1:0] left_q, left_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          err_q, err_d;
  logic          first_q, first_d;

  logic          accept_s, illegal_s, pick_r_s;
  logic [AW-1:0] parent_s, child_idx_s;
  logic [AW:0]   lchild_s, rchild_s;
  logic [DW-1:0] child_val_s;

  // Child indices carry one extra bit so 2i+2 never aliases onto a live node.
  assign parent_s    = (hole_q - IDX_ONE) >> 1;
  assign lchild_s    = {hole_q, 1'b1};
  assign rchild_s    = {hole_q, 1'b0} + IDX_TWO;
  assign pick_r_s    = (rchild_s < count_q) && better(mem_dout, left_q);
  assign child_val_s = pick_r_s ? mem_dout : left_q;
  assign child_idx_s = pick_r_s ? rchild_s[AW-1:0] : lchild_s[AW-1:0];

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept_s  = cmd_valid && cmd_ready;
  assign illegal_s = cmd_op ? (count_q == '0) : (count_q == DEPTH);

  assign rsp_valid = (state_q == S_WR) || (state_q == S_DONE);
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;
  assign count     = count_q;
  assign full      = (count_q == DEPTH);
  assign empty     = (count_q == '0);

  // Next-state and memory-port decode; writes in the compare states use mem_dout directly.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hole_d     = hole_q;
    key_d      = key_q;
    left_d     = left_q;
    rsp_data_d = rsp_data_q;
    err_d      = 1'b0;
    first_d    = first_q;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_din    = '0;
    case (state_q)
      S_IDLE: begin
        if (accept_s && illegal_s) begin
          err_d = 1'b1;
        end else if (accept_s && !cmd_op) begin
          key_d   = cmd_data;
          hole_d  = count_q[AW-1:0];
          count_d = count_q + CNT_ONE;
          state_d = (count_q == '0) ? S_WR : S_PU_RD;
        end else if (accept_s) begin
          count_d = count_q - CNT_ONE;
          state_d = S_PO_ROOT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PU_RD: begin
        mem_addr = parent_s;
        state_d  = S_PU_CMP;
      end
      S_PU_CMP: begin
        mem_addr = hole_q;
        if (better(key_q, mem_dout)) begin
          mem_we  = 1'b1;
          mem_din = mem_dout;
          hole_d  = parent_s;
          state_d = (parent_s == '0) ? S_WR : S_PU_RD;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        mem_addr = hole_q;
        mem_we   = 1'b1;
        mem_din  = key_q;
        state_d  = S_IDLE;
      end
      S_PO_ROOT: begin
        mem_addr = '0;
        state_d  = S_PO_LAST;
      end
      S_PO_LAST: begin
        rsp_data_d = mem_dout;
        mem_addr   = count_q[AW-1:0];
        if (count_q == '0) begin
          state_d = S_DONE;
        end else begin
          hole_d  = '0;
          first_d = 1'b1;
          state_d = S_PD_RDL;
        end
      end
      S_PD_RDL: begin
        // The displaced last key lands here only on the first pass.
        if (first_q) begin
          key_d = mem_dout;
        end else begin
          key_d = key_q;
        end
        first_d  = 1'b0;
        mem_addr = lchild_s[AW-1:0];
        state_d  = (lchild_s < count_q) ? S_PD_RDR : S_WR;
      end
      S_PD_RDR: begin
        left_d   = mem_dout;
        mem_addr = rchild_s[AW-1:0];
        state_d  = S_PD_CMP;
      end
      S_PD_CMP: begin
        if (better(child_val_s, key_q)) begin
          mem_addr = hole_q;
          mem_we   = 1'b1;
          mem_din  = child_val_s;
          hole_d   = child_idx_s;
          state_d  = S_PD_RDL;
        end else begin
          state_d = S_WR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; heap memory contents are left as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      hole_q     <= '0;
      key_q      <= '0;
      left_q     <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hole_q     <= hole_d;
      key_q      <= key_d;
      left_q     <= left_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      first_q    <= first_d;
    end
  end

endmodule

// File: tb/tb_heap_ctrl.sv
// Self-checking bench for heap_ctrl: vector table, scoreboard monitor, timing sequences.
module tb_heap_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef HEAP_MAX_EN
  localparam bit IS_MAX = 1'b1;
`else
  localparam bit IS_MAX = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          err;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  heap_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .err(err), .count(count), .full(full), .empty(empty),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory model
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  typedef struct {
    logic          is_err;
    logic          chk;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic          op;
    logic [DW-1:0] data;
    logic          exp_err;
    logic [DW-1:0] exp_data;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every response or error pulse consumes one expectation
  always @(negedge clk) begin
    if (!rst && (rsp_valid || err)) begin
      chk("rsp_err_exclusive", 32'(rsp_valid & err), 32'd0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: rsp_valid=%0b err=%0b with nothing expected", rsp_valid, err);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_kind_err", 32'(err), 32'(mon_e.is_err));
        if (mon_e.chk) chk("pop_data", rsp_data, mon_e.data);
      end
    end
  end

  task automatic send(input logic op, input logic [DW-1:0] data, input logic is_err,
                      input logic [DW-1:0] exp_data, input logic chk_data);
    int   n = 0;
    exp_t e;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: cmd_ready=%0b expected 1", cmd_ready);
    end
    e.is_err = is_err;
    e.chk    = chk_data;
    e.data   = exp_data;
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!cmd_ready || sb.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(cmd_ready && sb.size() == 0), 32'd1);
  endtask

  task automatic add_vec(input logic op, input logic [DW-1:0] d, input logic e, input logic [DW-1:0] x);
    vec_t v;
    v.op = op; v.data = d; v.exp_err = e; v.exp_data = x;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = '0;

    // Vector table: {op, data, expected err, expected popped key}
    add_vec(1'b0, 32'd5, 1'b0, 32'd0);
    add_vec(1'b0, 32'd3, 1'b0, 32'd0);
    add_vec(1'b0, 32'd8, 1'b0, 32'd0);
    add_vec(1'b0, 32'd1, 1'b0, 32'd0);
    add_vec(1'b1, 32'd0, 1'b0, IS_MAX ? 32'd8 : 32'd1);
    add_vec(1'b1, 32'd0, 1'b0, IS_MAX ? 32'd5 : 32'd3);
    add_vec(1'b1, 32'd0, 1'b0, IS_MAX ? 32'd3 : 32'd5);
    add_vec(1'b1, 32'd0, 1'b0, IS_MAX ? 32'd1 : 32'd8);
    add_vec(1'b1, 32'd0, 1'b1, 32'd0);
    add_vec(1'b0, 32'd7, 1'b0, 32'd0);
    add_vec(1'b0, 32'd7, 1'b0, 32'd0);
    add_vec(1'b0, 32'd2, 1'b0, 32'd0);
    add_vec(1'b0, 32'd7, 1'b0, 32'd0);
    add_vec(1'b1, 32'd0, 1'b0, IS_MAX ? 32'd7 : 32'd2);
    add_vec(1'b1, 32'd0, 1'b0, 32'd7);
    add_vec(1'b1, 32'd0, 1'b0, 32'd7);
    add_vec(1'b1, 32'd0, 1'b0, IS_MAX ? 32'd2 : 32'd7);
    add_vec(1'b0, 32'd4, 1'b0, 32'd0);
    add_vec(1'b0, 32'd9, 1'b0, 32'd0);
    add_vec(1'b0, 32'd1, 1'b0, 32'd0);
    add_vec(1'b1, 32'd0, 1'b0, IS_MAX ? 32'd9 : 32'd1);
    add_vec(1'b1, 32'd0, 1'b0, 32'd4);
    add_vec(1'b1, 32'd0, 1'b0, IS_MAX ? 32'd1 : 32'd9);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Pop on empty
    send(1'b1, 32'd0, 1'b1, 32'd0, 1'b0);
    chk("empty_pop_err", 32'(err), 32'd1);
    chk("empty_pop_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("empty_pop_err_pulse", 32'(err), 32'd0);
    chk("empty_pop_rsp_data", rsp_data, 32'd0);
    chk("empty_pop_count", 32'(count), 32'd0);

    // Single push into empty: write and rsp_valid at T+1, ready at T+2
    send(1'b0, 32'h1234, 1'b0, 32'd0, 1'b0);
    chk("push1_rsp_t1", 32'(rsp_valid), 32'd1);
    chk("push1_we_t1", 32'(mem_we), 32'd1);
    chk("push1_addr_t1", 32'(mem_addr), 32'd0);
    chk("push1_din_t1", mem_din, 32'h1234);
    chk("push1_count_t1", 32'(count), 32'd1);
    chk("push1_ready_t1", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("push1_ready_t2", 32'(cmd_ready), 32'd1);
    chk("push1_rsp_t2", 32'(rsp_valid), 32'd0);

    // Pop of last key: rsp_valid exactly at T+3, ready at T+4
    send(1'b1, 32'd0, 1'b0, 32'h1234, 1'b1);
    chk("pop1_rsp_t1", 32'(rsp_valid), 32'd0);
    chk("pop1_empty_t1", 32'(empty), 32'd1);
    @(posedge clk); #1;
    chk("pop1_rsp_t2", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("pop1_rsp_t3", 32'(rsp_valid), 32'd1);
    chk("pop1_data_t3", rsp_data, 32'h1234);
    chk("pop1_ready_t3", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("pop1_ready_t4", 32'(cmd_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < vq.size(); i++) begin
      send(vq[i].op, vq[i].data, vq[i].exp_err, vq[i].exp_data, vq[i].op & ~vq[i].exp_err);
    end
    wait_idle();
    chk("table_count", 32'(count), 32'd0);
    chk("table_empty", 32'(empty), 32'd1);

    // Fill to capacity, overflow, then drain in order
    for (int i = 0; i < 32; i++) send(1'b0, 32'(31 - i), 1'b0, 32'd0, 1'b0);
    wait_idle();
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd32);
    send(1'b0, 32'd99, 1'b1, 32'd0, 1'b0);
    wait_idle();
    chk("overflow_count", 32'(count), 32'd32);
    for (int i = 0; i < 32; i++) send(1'b1, 32'd0, 1'b0, IS_MAX ? 32'(31 - i) : 32'(i), 1'b1);
    wait_idle();
    chk("drain_empty", 32'(empty), 32'd1);

    // Reset in the middle of a sift-down
    for (int i = 0; i < 16; i++) send(1'b0, 32'((i * 37) % 101), 1'b0, 32'd0, 1'b0);
    wait_idle();
    send(1'b1, 32'd0, 1'b0, 32'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy", 32'(cmd_ready), 32'd0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_rsp", 32'(rsp_valid), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    send(1'b1, 32'd0, 1'b1, 32'd0, 1'b0);
    wait_idle();
    chk("abort_count_after", 32'(count), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/heap_ctrl.md
# heap_ctrl

Heap engine that sits directly upstream of the heap data memory in the sorting datapath. It accepts push and pop commands over a valid/ready handshake. It maintains a binary min-heap of up to 32 unsigned words by driving a single synchronous-read memory port, wired to the node-list port of the data store. Pops return the current extreme key, so a stream of pushes followed by pops yields sorted output.

## Interface
- DW, 32, key/data width in bits
- AW, 5, memory address width; heap capacity DEPTH = 2^AW = 32
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle; command accepted on cmd_valid & cmd_ready
- cmd_op  in  1  0 = push, 1 = pop
- cmd_data  in  DW  key for push (ignored for pop)
- rsp_valid  out  1  one-cycle pulse: operation complete
- rsp_data  out  DW  popped key, held until next successful pop
- err  out  1  one-cycle pulse: push when full or pop when empty
- count  out  AW+1  number of keys in heap (0..32)
- full / empty  out  1  count==32 / count==0
- mem_addr  out  AW  memory address
- mem_we  out  1  memory write enable
- mem_din  out  DW  memory write data
- mem_dout  in  DW  memory read data, valid the cycle after mem_addr is presented with mem_we=0

## Operation
- Heap layout: 0-based, parent(i)=(i-1)>>1, children 2i+1, 2i+2. Comparison is unsigned, strict "better than": less-than for a min-heap. Equal keys never move.
- Reset values: state IDLE, count=0, rsp_valid=0, err=0, rsp_data=0, mem_we=0, mem_addr=0, mem_din=0. cmd_ready=0 while rst is high. Memory contents are not cleared; they are treated as empty.
- cmd_ready=1 only in IDLE. It is asserted the first cycle after rst is deasserted.
- Illegal command (push when full, pop when empty): accepted, err pulses the next cycle, no state change, no rsp_valid, engine stays IDLE.
- Push (hole-based sift-up): on accept, key<=cmd_data, hole<=count, count<=count+1.
  - If hole==0, go to WR.
  - PU_RD: read parent(hole).
  - PU_CMP: if key better than mem_dout, write mem_dout at hole and set hole<=parent. Go to WR if the new hole==0, else back to PU_RD. Otherwise go to WR.
  - WR: write key at hole; rsp_valid pulses; return to IDLE.
- Pop (hole-based sift-down): on accept, count<=count-1.
  - PO_ROOT: read 0.
  - PO_LAST: capture rsp_data<=mem_dout; read address new count into key.
  - If new count==0, go to DONE (no write). Otherwise hole<=0 and continue.
  - PD_RDL: read left child if it is < count, else go to WR.
  - PD_RDR: capture left; read right if it is < count.
  - PD_CMP: choose the better child (left wins ties or when right is absent). If the child is better than key, write child at hole, set hole<=child index, go to PD_RDL. Otherwise go to WR.
  - WR / DONE: rsp_valid pulses; return to IDLE.
- Child indices are computed at AW+1 bits so that 2i+2 cannot wrap; any index >= count is treated as absent.
- The engine ignores cmd_valid outside IDLE; there is no queueing.

## Timing
- Memory read latency is exactly 1 cycle. Each read state issues an address; the following state consumes mem_dout.
- Push into an empty heap, accepted at cycle T: write at T+1, rsp_valid at T+1, cmd_ready=1 at T+2.
- Push latency is 2 + 2·(levels climbed) cycles; worst case at depth 4 is 10 cycles.
- Pop of the last key: PO_ROOT T+1, PO_LAST T+2, DONE T+3 (rsp_valid), IDLE T+4.
- Pop sift-down costs 3 cycles per level plus the final write.
- count, full and empty update the cycle after accept.
- rsp_data updates in PO_LAST and is stable when rsp_valid pulses.
- err and rsp_valid are never asserted together.
- rst during any state aborts the operation next edge: IDLE, count=0, and no rsp_valid or err pulses.

## Configuration
- HEAP_MAX_EN defined: comparisons invert (strict greater-than), giving a max-heap; pops return descending order.
- HEAP_MAX_EN undefined (default): min-heap, ascending pops.
- Interface and timing are identical in both builds.

## Test plan
- Push 5, 3, 8, 1, then pop ×4 -> rsp_data 1, 3, 5, 8. count ends at 0 and empty=1.
- Push 32 keys 31..0 -> full=1. A 33rd push -> err pulse, count stays 32. Then 32 pops -> 0..31 in order.
- Pop on empty after reset -> err pulse next cycle, rsp_valid=0, rsp_data stays 0.
- Push 7, 7, 2, 7 -> pops 2, 7, 7, 7. Single push into empty -> rsp_valid exactly at T+1.
- Assert rst mid sift-down of a 16-key heap -> next cycle count=0, cmd_ready=1, mem_we=0. A subsequent pop -> err.
- With HEAP_MAX_EN: push 4, 9, 1 -> pops 9, 4, 1.
